// File: rtl/ymz_pcm_rom_arb.sv
// YMZ280B sample-ROM read arbiter: decodes each 24-bit byte read onto one of
// three 4 MB PCM SDRAM slots, keeps a one-entry last-byte cache, and answers
// out-of-range or timed-out reads with zero.
module ymz_pcm_rom_arb #(
  parameter int OK_SKIP = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic        REQ_RD,
  input  logic [23:0] REQ_ADDR,
  output logic        REQ_WAIT,
  output logic        REQ_VALID,
  output logic [7:0]  REQ_DOUT,
  output logic        PCM_CS,
  output logic [21:0] PCM_ADDR,
  input  logic        PCM_OK,
  input  logic [7:0]  PCM_DOUT,
  output logic        PCM1_CS,
  output logic [21:0] PCM1_ADDR,
  input  logic        PCM1_OK,
  input  logic [7:0]  PCM1_DOUT,
  output logic        PCM2_CS,
  output logic [21:0] PCM2_ADDR,
  input  logic        PCM2_OK,
  input  logic [7:0]  PCM2_DOUT,
  output logic        TIMEOUT_ERR
);

  localparam int CYC_W = $clog2(TIMEOUT + 1);
  localparam logic [CYC_W-1:0] SKIP_C = CYC_W'(OK_SKIP);
  localparam logic [CYC_W-1:0] TOUT_C = CYC_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic [1:0]       bank;
  logic [23:0]      addr_q;
  logic [7:0]       resp_data;
  logic             cache_vld;
  logic [23:0]      cache_addr;
  logic [7:0]       cache_data;
  logic             sel_ok;
  logic [7:0]       sel_dout;

  // Route the handshake of the bank selected by the captured address.
  always_comb begin
    sel_ok   = 1'b0;
    sel_dout = 8'h00;
    case (bank)
      2'd0: begin sel_ok = PCM_OK;  sel_dout = PCM_DOUT;  end
      2'd1: begin sel_ok = PCM1_OK; sel_dout = PCM1_DOUT; end
      2'd2: begin sel_ok = PCM2_OK; sel_dout = PCM2_DOUT; end
      default: begin sel_ok = 1'b0; sel_dout = 8'h00; end
    endcase
  end

  // Request sequencer: capture/decode in IDLE, hold the bank request in FETCH,
  // strobe the byte out in RESP.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state       <= IDLE;
      cyc         <= '0;
      REQ_WAIT    <= 1'b0;
      REQ_VALID   <= 1'b0;
      REQ_DOUT    <= 8'h00;
      PCM_CS      <= 1'b0;
      PCM1_CS     <= 1'b0;
      PCM2_CS     <= 1'b0;
      PCM_ADDR    <= '0;
      PCM1_ADDR   <= '0;
      PCM2_ADDR   <= '0;
      cache_vld   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      REQ_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_RD) begin
            addr_q   <= REQ_ADDR;
            bank     <= REQ_ADDR[23:22];
            cyc      <= '0;
            REQ_WAIT <= 1'b1;
            if (cache_vld && (REQ_ADDR == cache_addr)) begin
              resp_data <= cache_data;
              state     <= RESP;
            end else if (REQ_ADDR[23:22] == 2'd3) begin
              // Top quarter of the address space has no backing slot.
              resp_data <= 8'h00;
              state     <= RESP;
            end else begin
              state <= FETCH;
              case (REQ_ADDR[23:22])
                2'd0:    begin PCM_CS  <= 1'b1; PCM_ADDR  <= REQ_ADDR[21:0]; end
                2'd1:    begin PCM1_CS <= 1'b1; PCM1_ADDR <= REQ_ADDR[21:0]; end
                default: begin PCM2_CS <= 1'b1; PCM2_ADDR <= REQ_ADDR[21:0]; end
              endcase
            end
          end
        end
        FETCH: begin
          // OK seen in the first OK_SKIP cycles may belong to a previous access.
          if (sel_ok && (cyc >= SKIP_C)) begin
            resp_data  <= sel_dout;
            cache_addr <= addr_q;
            cache_data <= sel_dout;
            cache_vld  <= 1'b1;
            PCM_CS     <= 1'b0;
            PCM1_CS    <= 1'b0;
            PCM2_CS    <= 1'b0;
            state      <= RESP;
          end else if (cyc == TOUT_C) begin
            resp_data   <= 8'h00;
            TIMEOUT_ERR <= 1'b1;
            cache_vld   <= 1'b0;
            PCM_CS      <= 1'b0;
            PCM1_CS     <= 1'b0;
            PCM2_CS     <= 1'b0;
            state       <= RESP;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        RESP: begin
          REQ_VALID <= 1'b1;
          REQ_DOUT  <= resp_data;
          REQ_WAIT  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
